// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM encoding.
package nibble_serial_adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshakes of the nibble-serial adder.
// master = operand source / result consumer, slave = the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is flattened straight from the generate/propagate terms
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum  = w_p ^ w_c[3:0];
  assign cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder: one shared CLA slice processes a nibble per cycle,
// LSB first, between a valid/ready operand port and a valid/ready result port.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);

  localparam int NN    = WIDTH / NIBBLE;
  localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [WIDTH-1:0]   w_a_sh;
  logic [WIDTH-1:0]   w_b_sh;
  logic [NIBBLE-1:0]  w_a_nib;
  logic [NIBBLE-1:0]  w_b_nib;
  logic [NIBBLE-1:0]  w_nib_sum;
  logic               w_nib_cout;
  logic [WIDTH-1:0]   w_mask;
  logic [WIDTH-1:0]   w_ins;
  logic               w_ovf;

  // Nibble mux: shift the current nibble down to bit 0 rather than slicing,
  // so the select stays in range for every legal WIDTH.
  assign w_a_sh  = r_a >> (NIBBLE * int'(r_idx));
  assign w_b_sh  = r_b >> (NIBBLE * int'(r_idx));
  assign w_a_nib = w_a_sh[NIBBLE-1:0];
  assign w_b_nib = w_b_sh[NIBBLE-1:0];

  cla4_slice u_cla (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_nib_sum),
    .cout (w_nib_cout)
  );

  // Read-modify-write of the sum register at the current nibble position
  assign w_mask = WIDTH'(4'hF) << (NIBBLE * int'(r_idx));
  assign w_ins  = WIDTH'(w_nib_sum) << (NIBBLE * int'(r_idx));

  // Only meaningful on the last nibble, where the slice sum MSB is sum[WIDTH-1]
  assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_nib_sum[NIBBLE-1] != r_a[WIDTH-1]);

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

  // Control FSM with operand, sum and carry registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_carry    <= bus.cin;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum   <= (r_sum & ~w_mask) | w_ins;
          r_carry <= w_nib_cout;
          if (r_idx == IDX_LAST) begin
            r_idx       <= '0;
            r_cout      <= w_nib_cout;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
